// File: rtl/demux_serial_sender_pkg.sv
// rtl/demux_serial_sender_pkg.sv - shared channel width and frame state encodings for the demux sender
package demux_serial_sender_pkg;

    // Channel select width: one bit per level of the 1-to-8 demux tree.
    localparam int CHAN_W = 3;

    // Encodings are fixed so the demux-side checker/receiver can decode them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/demux_shift_reg.sv
// rtl/demux_shift_reg.sv - parallel-load shift register feeding the serial data bit
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           capture load_data (takes priority over shift)
//   load_data      WIDTH-bit word to serialise
//   shift          advance one bit toward serial_bit
//   serial_bit     bit currently at the output end (bit0 or bit WIDTH-1)
module demux_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             serial_bit
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                data_d = data_q << 1;
            end else begin
                data_d = data_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign serial_bit = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/demux_serial_sender.sv
// rtl/demux_serial_sender.sv - framed serial sender driving the 1-to-8 demux tree selects
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready word handshake; accepted when both high (ready only in IDLE)
//   in_data           WIDTH-bit word to send
//   in_chan           destination channel 0..7
//   x                 serial frame: start(1), WIDTH data bits, STOP_BITS zeros
//   s1/s2/s3          in_chan[2]/[1]/[0], held stable for the whole frame
//   busy              frame in progress
//   done              one-cycle pulse in the last stop-bit cycle
module demux_serial_sender
    import demux_serial_sender_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [CHAN_W-1:0] in_chan,
    output logic              in_ready,
    output logic              x,
    output logic              s1,
    output logic              s2,
    output logic              s3,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCNT_W = $clog2(STOP_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [SCNT_W-1:0] LAST_STOP = SCNT_W'(STOP_BITS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SCNT_W-1:0]  stop_cnt_q, stop_cnt_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic               x_q, x_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ready_q, in_ready_d;
    logic               accept;
    logic               shift_en;
    logic               serial_bit;

    assign accept = in_valid && in_ready_q;

    demux_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_data  (in_data),
        .shift      (shift_en),
        .serial_bit (serial_bit)
    );

    // Outputs are registered, so every *_d below is the value for the state
    // being entered: x_d carries the bit of the next cycle, and the shift
    // register advances on the same edge that bit is captured into x_q.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        chan_d     = chan_q;
        x_d        = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        in_ready_d = 1'b0;
        shift_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                in_ready_d = 1'b1;
                if (accept) begin
                    state_d    = ST_START;
                    chan_d     = in_chan;
                    x_d        = 1'b1;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                end
            end
            ST_START: begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
                x_d       = serial_bit;
                shift_en  = 1'b1;
            end
            ST_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = '0;
                    done_d     = (STOP_BITS == 1);
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    x_d       = serial_bit;
                    shift_en  = 1'b1;
                end
            end
            ST_STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b1;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    done_d     = ((stop_cnt_q + 1'b1) == LAST_STOP);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            chan_q     <= '0;
            x_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            chan_q     <= chan_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign x        = x_q;
    assign s1       = chan_q[2];
    assign s2       = chan_q[1];
    assign s3       = chan_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_demux_serial_sender.sv
// tb/tb_demux_serial_sender.sv - directed self-checking bench for demux_serial_sender
module tb_demux_serial_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_valid = 1'b0;
    logic [7:0] a_data  = 8'h00;
    logic [2:0] a_chan  = 3'd0;
    logic       a_ready, a_x, a_s1, a_s2, a_s3, a_busy, a_done;

    logic       b_valid = 1'b0;
    logic [7:0] b_data  = 8'h00;
    logic [2:0] b_chan  = 3'd0;
    logic       b_ready, b_x, b_s1, b_s2, b_s3, b_busy, b_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    demux_serial_sender #(.WIDTH(8), .STOP_BITS(1), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_chan(a_chan),
        .in_ready(a_ready), .x(a_x), .s1(a_s1), .s2(a_s2), .s3(a_s3),
        .busy(a_busy), .done(a_done)
    );

    demux_serial_sender #(.WIDTH(8), .STOP_BITS(1), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_chan(b_chan),
        .in_ready(b_ready), .x(b_x), .s1(b_s1), .s2(b_s2), .s3(b_s3),
        .busy(b_busy), .done(b_done)
    );

    // {x, s1, s2, s3, busy, done, in_ready}
    function automatic logic [6:0] obs_a();
        return {a_x, a_s1, a_s2, a_s3, a_busy, a_done, a_ready};
    endfunction

    function automatic logic [6:0] obs_b();
        return {b_x, b_s1, b_s2, b_s3, b_busy, b_done, b_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word on instance a and returns at the sample point of its START cycle.
    task automatic send_a(input logic [7:0] d, input logic [2:0] c);
        int n = 0;
        a_data  = d;
        a_chan  = c;
        a_valid = 1'b1;
        while (a_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (a_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_a_timeout ready=%b required=1", a_ready);
        end
        tick();
        a_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] o;
        repeat (2) tick();
        tests_run++;
        o = obs_a();
        if (o !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_held got=%b required=%b", o, 7'b0);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({a_ready, b_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ready_after_release got=%b required=11", {a_ready, b_ready});
        end
        send_a(8'h00, 3'd5);
        tests_run++;
        o = obs_a();
        if (o !== 7'b1_101_1_0_0) begin
            tests_failed++;
            $display("FAIL reset_pre_start got=%b required=%b", o, 7'b1101100);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        o = obs_a();
        if (o !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_async got=%b required=%b", o, 7'b0);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [0:9] ex;
        logic [6:0] o, e;
        logic [7:0] y_mask;
        ex = 10'b1101001010;
        y_mask = 8'h00;
        send_a(8'hA5, 3'd5);
        for (int k = 0; k < 10; k++) begin
            o = obs_a();
            e = {ex[k], 3'b101, 1'b1, (k == 9), 1'b0};
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL single_frame cyc=%0d got=%b required=%b", k, o, e);
            end
            if (a_x === 1'b1) y_mask[{a_s1, a_s2, a_s3}] = 1'b1;
            tick();
        end
        tests_run++;
        if (y_mask !== 8'b0010_0000) begin
            tests_failed++;
            $display("FAIL demux_route got=%b required=%b", y_mask, 8'b00100000);
        end
        o = obs_a();
        tests_run++;
        if (o !== 7'b0_101_0_0_1) begin
            tests_failed++;
            $display("FAIL single_idle got=%b required=%b", o, 7'b0101001);
        end
    endtask

    task automatic test_msb_first();
        logic [0:9] ex;
        logic [6:0] o, e;
        int n = 0;
        ex = 10'b1100000000;
        b_data  = 8'h80;
        b_chan  = 3'd0;
        b_valid = 1'b1;
        while (b_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (b_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL msb_timeout ready=%b required=1", b_ready);
        end
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            o = obs_b();
            e = {ex[k], 3'b000, 1'b1, (k == 9), 1'b0};
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL msb_first cyc=%0d got=%b required=%b", k, o, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [0:9] ex1, ex2;
        logic [6:0] o, e;
        ex1 = 10'b1001111000;
        ex2 = 10'b1110000110;
        send_a(8'h3C, 3'd7);
        a_valid = 1'b1;
        a_data  = 8'hC3;
        a_chan  = 3'd2;
        for (int k = 0; k < 21; k++) begin
            if (k < 10) begin
                e = {ex1[k], 3'b111, 1'b1, (k == 9), 1'b0};
            end else if (k == 10) begin
                e = {1'b0, 3'b111, 1'b0, 1'b0, 1'b1};
            end else begin
                e = {ex2[k-11], 3'b010, 1'b1, (k == 20), 1'b0};
                a_valid = 1'b0;
            end
            o = obs_a();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d got=%b required=%b", k, o, e);
            end
            tick();
        end
    endtask

    task automatic test_input_change();
        logic [0:9] ex;
        logic [6:0] o, e;
        ex = 10'b1010110100;
        send_a(8'h5A, 3'd3);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                a_data  = 8'hFF;
                a_chan  = 3'd6;
                a_valid = 1'b1;
            end
            if (k == 8) a_valid = 1'b0;
            o = obs_a();
            e = {ex[k], 3'b011, 1'b1, (k == 9), 1'b0};
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL input_change cyc=%0d got=%b required=%b", k, o, e);
            end
            tick();
        end
        tick();
        tests_run++;
        if (a_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_valid busy=%b required=0", a_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:9] ex;
        logic [6:0] o, e;
        send_a(8'hFF, 3'd6);
        repeat (5) tick();
        tests_run++;
        o = obs_a();
        if (o !== 7'b1_110_1_0_0) begin
            tests_failed++;
            $display("FAIL pre_reset_bit4 got=%b required=%b", o, 7'b1110100);
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            o = obs_a();
            tests_run++;
            if (o !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_frame cyc=%0d got=%b required=%b", k, o, 7'b0);
            end
            tick();
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (obs_a() !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL post_reset_idle got=%b required=%b", obs_a(), 7'b0000001);
        end
        ex = 10'b1111100000;
        send_a(8'h0F, 3'd1);
        for (int k = 0; k < 10; k++) begin
            o = obs_a();
            e = {ex[k], 3'b001, 1'b1, (k == 9), 1'b0};
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL post_reset_frame cyc=%0d got=%b required=%b", k, o, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_msb_first();
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
